// File: rtl/gate_pkg.sv
// gate_pkg: shared types for the parking gate scheduler.
// FSM states, spot indexing, dwell counter width.
package gate_pkg;

  localparam int NUM_SPOTS = 4;
  localparam int SPOT_W    = 2;
  localparam int DWELL_W   = 16;

  typedef logic [SPOT_W-1:0] spot_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_GRANT,
    S_OPEN,
    S_CLOSE
  } state_e;

  typedef enum logic {
    SIDE_ENTRY = 1'b0,
    SIDE_EXIT  = 1'b1
  } side_e;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/spot_finder.sv
// spot_finder: lowest-index free spot of the occupancy map.
// none_free_o flags a full lot.
module spot_finder
  import gate_pkg::*;
(
  input  logic [NUM_SPOTS-1:0] f_i,
  output spot_t                index_o,
  output logic                 none_free_o
);

  // priority encode the first zero bit
  always_comb begin
    index_o     = '0;
    none_free_o = 1'b0;
    unique casez (f_i)
      4'b???0: index_o = 2'd0;
      4'b??01: index_o = 2'd1;
      4'b?011: index_o = 2'd2;
      4'b0111: index_o = 2'd3;
      default: none_free_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/gate_scheduler.sv
// gate_scheduler: shared entry/exit gate arbiter with occupancy map.
// Optional per-spot dwell timers when GATE_TIMER_EN is defined.
module gate_scheduler
  import gate_pkg::*;
#(
  parameter int DOOR_CYCLES = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        enter_req,
  input  logic        exit_req,
  input  logic [1:0]  exit_spot,
  output logic        enter_grant,
  output logic        exit_grant,
  output logic        exit_err,
  output logic        door_open,
  output logic [1:0]  L,
  output logic [3:0]  F,
  output logic [2:0]  capacity,
  output logic        full,
  output logic        busy,
  output logic [63:0] spot_time
);

  state_e      state_q, state_d;
  side_e       side_q, side_d;
  side_e       last_q, last_d;
  spot_t       spot_q, spot_d;
  spot_t       L_q, L_d;
  logic [3:0]  F_q, F_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        err_q, err_d;

  spot_t       free_idx;
  logic        none_free;
  logic        en_ok;
  logic        ex_ok;

  spot_finder u_find (
    .f_i         (F_q),
    .index_o     (free_idx),
    .none_free_o (none_free)
  );

  assign en_ok = enter_req & ~none_free;
  assign ex_ok = exit_req & F_q[exit_spot];

  // state and datapath registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      side_q  <= SIDE_ENTRY;
      last_q  <= SIDE_ENTRY;
      spot_q  <= '0;
      L_q     <= '0;
      F_q     <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      side_q  <= side_d;
      last_q  <= last_d;
      spot_q  <= spot_d;
      L_q     <= L_d;
      F_q     <= F_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // arbitration, passage sequencing and map update
  always_comb begin
    state_d = state_q;
    side_d  = side_q;
    last_d  = last_q;
    spot_d  = spot_q;
    L_d     = L_q;
    F_d     = F_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        err_d = exit_req & ~F_q[exit_spot];
        if (en_ok | ex_ok) begin
          state_d = S_GRANT;
          spot_d  = exit_spot;
          if (en_ok & ex_ok)
            side_d = (last_q == SIDE_ENTRY) ? SIDE_EXIT : SIDE_ENTRY;
          else
            side_d = ex_ok ? SIDE_EXIT : SIDE_ENTRY;
        end
      end
      S_GRANT: begin
        state_d = S_OPEN;
        cnt_d   = 4'(DOOR_CYCLES - 1);
        last_d  = side_q;
        if (side_q == SIDE_ENTRY) begin
          F_d[free_idx] = 1'b1;
          L_d           = free_idx;
        end else begin
          F_d[spot_q] = 1'b0;
        end
      end
      S_OPEN: begin
        if (cnt_q == 4'd0) state_d = S_CLOSE;
        else cnt_d = cnt_q - 4'd1;
      end
      S_CLOSE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign enter_grant = (state_q == S_GRANT) && (side_q == SIDE_ENTRY);
  assign exit_grant  = (state_q == S_GRANT) && (side_q == SIDE_EXIT);
  assign exit_err    = err_q;
  assign door_open   = (state_q == S_OPEN);
  assign busy        = (state_q != S_IDLE);
  assign L           = L_q;
  assign F           = F_q;
  assign full        = (F_q == 4'b1111);
  assign capacity    = 3'(NUM_SPOTS) - popcount4(F_q);

`ifdef GATE_TIMER_EN
  logic [3:0] alloc;

  // one-hot of the spot being allocated on this edge
  always_comb begin
    alloc = '0;
    if (enter_grant) alloc[free_idx] = 1'b1;
  end

  for (genvar i = 0; i < NUM_SPOTS; i++) begin : g_tmr
    logic [DWELL_W-1:0] tmr_q;

    // saturating dwell counter, restarted on allocation
    always_ff @(posedge CLK or posedge RST) begin
      if (RST) tmr_q <= '0;
      else if (alloc[i]) tmr_q <= '0;
      else if (F_q[i] && (tmr_q != {DWELL_W{1'b1}}))
        tmr_q <= tmr_q + 1'b1;
    end

    assign spot_time[DWELL_W*i +: DWELL_W] = tmr_q;
  end
`else
  assign spot_time = '0;
`endif

endmodule

// File: tb/tb_gate_scheduler.sv
// tb_gate_scheduler: scoreboard bench for gate_scheduler.
// Directed scenarios plus random traffic against an occupancy model.
module tb_gate_scheduler;

  localparam int D = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        enter_req = 1'b0;
  logic        exit_req = 1'b0;
  logic [1:0]  exit_spot = 2'd0;
  logic        enter_grant, exit_grant, exit_err, door_open;
  logic [1:0]  L;
  logic [3:0]  F;
  logic [2:0]  capacity;
  logic        full, busy;
  logic [63:0] spot_time;

  gate_scheduler #(.DOOR_CYCLES(D)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .enter_req   (enter_req),
    .exit_req    (exit_req),
    .exit_spot   (exit_spot),
    .enter_grant (enter_grant),
    .exit_grant  (exit_grant),
    .exit_err    (exit_err),
    .door_open   (door_open),
    .L           (L),
    .F           (F),
    .capacity    (capacity),
    .full        (full),
    .busy        (busy),
    .spot_time   (spot_time)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  typedef struct {
    int         kind;
    int         cyc;
    int         L;
    logic [3:0] F;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  bit   mon_off = 1'b0;

  logic [3:0] m_F = 4'b0;
  int         m_L = 0;
  bit         m_last_exit = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", nm);
  endtask

  function automatic int lowest_free();
    for (int i = 0; i < 4; i++)
      if (!m_F[i]) return i;
    return -1;
  endfunction

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(negedge CLK);
      if (!busy && q.size() == 0) return;
    end
    fail_now("idle_wait");
  endtask

  task automatic wait_grant(input bit ex);
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK);
      if (ex ? exit_grant : enter_grant) return;
    end
    fail_now(ex ? "exit_grant_wait" : "enter_grant_wait");
  endtask

  task automatic do_enter();
    int idx;
    wait_idle();
    idx = lowest_free();
    m_F[idx] = 1'b1;
    m_L = idx;
    m_last_exit = 1'b0;
    q.push_back('{0, cyc + 1, idx, m_F});
    enter_req = 1'b1;
    wait_grant(1'b0);
    enter_req = 1'b0;
  endtask

  task automatic do_exit(input int s);
    wait_idle();
    exit_spot = 2'(s);
    if (m_F[s]) begin
      m_F[s] = 1'b0;
      m_last_exit = 1'b1;
      q.push_back('{1, cyc + 1, m_L, m_F});
      exit_req = 1'b1;
      wait_grant(1'b1);
      exit_req = 1'b0;
    end else begin
      q.push_back('{2, cyc + 1, m_L, m_F});
      exit_req = 1'b1;
      @(negedge CLK);
      exit_req = 1'b0;
    end
  endtask

  task automatic do_both(input int s, input int pre);
    bit ent_ok, ex_first;
    int n, idx;
    bit done;
    wait_idle();
    if (pre > 0) begin
      enter_req = 1'b1;
      repeat (pre) @(negedge CLK);
    end
    n = cyc;
    ent_ok = (m_F != 4'hF);
    ex_first = !ent_ok || !m_last_exit;
    for (int k = 0; k < 2; k++) begin
      if ((k == 0) == ex_first) begin
        m_F[s] = 1'b0;
        m_last_exit = 1'b1;
        q.push_back('{1, n + 1 + k * (D + 3), m_L, m_F});
      end else begin
        idx = lowest_free();
        m_F[idx] = 1'b1;
        m_L = idx;
        m_last_exit = 1'b0;
        q.push_back('{0, n + 1 + k * (D + 3), idx, m_F});
      end
    end
    exit_spot = 2'(s);
    exit_req = 1'b1;
    enter_req = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge CLK);
      if (enter_grant) enter_req = 1'b0;
      if (exit_grant) exit_req = 1'b0;
      done = !enter_req && !exit_req;
    end
    if (!done) fail_now("both_wait");
    enter_req = 1'b0;
    exit_req = 1'b0;
  endtask

  task automatic check_reset();
    chk("rst_F", F, 0);
    chk("rst_capacity", capacity, 4);
    chk("rst_full", full, 0);
    chk("rst_L", L, 0);
    chk("rst_door", door_open, 0);
    chk("rst_enter_grant", enter_grant, 0);
    chk("rst_exit_grant", exit_grant, 0);
    chk("rst_exit_err", exit_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_spot_time", spot_time, 0);
  endtask

  // monitor: pop expected event whenever the DUT reports one
  initial begin
    exp_t e;
    int   kind, n;
    forever begin
      @(negedge CLK);
      if (mon_off || RST) continue;
      if (enter_grant || exit_grant || exit_err) begin
        kind = enter_grant ? 0 : (exit_grant ? 1 : 2);
        if (enter_grant && exit_grant)
          chk("grant_onehot", 1, 0);
        if (q.size() == 0) begin
          chk("unexpected_event", kind, 99);
        end else begin
          e = q.pop_front();
          chk("event_kind", kind, e.kind);
          if (e.cyc >= 0) chk("event_cycle", cyc, e.cyc);
          if (kind == 2) begin
            chk("err_F", F, e.F);
            chk("err_door", door_open, 0);
          end else begin
            @(negedge CLK);
            chk("F", F, e.F);
            chk("L", L, e.L);
            chk("capacity", capacity, 4 - $countones(e.F));
            chk("full", full, e.F == 4'hF);
            n = 0;
            while (door_open && n < 40) begin
              n++;
              @(negedge CLK);
            end
            chk("door_cycles", n, D);
            chk("close_busy", busy, 1);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int op, s, cnt;
    int occ[$];
    int fre[$];
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    check_reset();
    RST = 1'b0;

    do_enter();
    repeat (21) @(negedge CLK);
`ifdef GATE_TIMER_EN
    chk("dwell_20", spot_time[15:0], 20);
`else
    chk("spot_time_zero", spot_time, 0);
`endif

    do_enter();
    do_enter();
    do_enter();
    do_both(1, 10);

    do_exit(0);
    do_exit(1);
    do_exit(3);
    do_enter();
    do_both(2, 0);

    do_exit(1);
    do_exit(3);

    for (int it = 0; it < 60; it++) begin
      op = $urandom_range(0, 3);
      occ.delete();
      fre.delete();
      for (int i = 0; i < 4; i++)
        if (m_F[i]) occ.push_back(i);
        else fre.push_back(i);
      cnt = occ.size();
      case (op)
        0: if (fre.size() > 0) do_enter();
           else do_both(occ[$urandom_range(0, cnt - 1)], 0);
        1: if (cnt > 0) do_exit(occ[$urandom_range(0, cnt - 1)]);
           else do_enter();
        2: if (fre.size() > 0)
             do_exit(fre[$urandom_range(0, fre.size() - 1)]);
           else do_exit(occ[$urandom_range(0, cnt - 1)]);
        default: if (cnt > 0) do_both(occ[$urandom_range(0, cnt - 1)], 0);
                 else do_enter();
      endcase
    end

    wait_idle();
    mon_off = 1'b1;
    if (m_F == 4'hF) begin
      exit_spot = 2'd0;
      exit_req = 1'b1;
      wait_grant(1'b1);
      exit_req = 1'b0;
      wait_idle();
    end
    enter_req = 1'b1;
    wait_grant(1'b0);
    enter_req = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("open2_door", door_open, 1);
    #2;
    RST = 1'b1;
    #1;
    chk("rst_mid_door", door_open, 0);
    chk("rst_mid_F", F, 0);
    chk("rst_mid_capacity", capacity, 4);
    @(negedge CLK);
    check_reset();
    RST = 1'b0;
    m_F = 4'b0;
    m_L = 0;
    m_last_exit = 1'b0;
    mon_off = 1'b0;
    do_enter();
    wait_idle();
    chk("queue_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gate_scheduler.md
GATE_SCHEDULER -- requirements
Module: gate_scheduler

Interface
REQ-001 SHALL have parameter DOOR_CYCLES, default 4 (range 1..15): number of cycles door_open is held per granted passage.
REQ-002 SHALL have ports, in this order:
- CLK  input  1  single clock; all state on rising edge.
- RST  input  1  reset, asynchronous, active-high.
- enter_req  input  1  level request from the entry lane; held until enter_grant.
- exit_req  input  1  level request from the exit lane; held until exit_grant.
- exit_spot  input  2  spot being vacated; valid while exit_req=1.
- enter_grant  output  1  one-cycle grant pulse to the entry lane.
- exit_grant  output  1  one-cycle grant pulse to the exit lane.
- exit_err  output  1  one-cycle pulse: exit request naming a free spot was dropped.
- door_open  output  1  shared gate drive.
- L  output  2  spot allocated by the most recent entry grant.
- F  output  4  occupancy map, bit i = spot i occupied.
- capacity  output  3  free spot count, 0..4.
- full  output  1  F == 4'b1111.
- busy  output  1  FSM not in IDLE.
- spot_time  output  64  four 16-bit dwell counters, spot i at bits [16i+15:16i].

Function
REQ-003 SHALL implement FSM states IDLE, GRANT, OPEN, CLOSE.
REQ-004 IDLE: eligible entry = enter_req & ~full; eligible exit = exit_req & F[exit_spot]; none eligible -> stay IDLE.
REQ-005 IDLE, exit_req=1 with F[exit_spot]=0 -> exit_err=1 next cycle, no grant, stay IDLE.
REQ-006 IDLE, exactly one eligible -> GRANT serving it; both eligible -> serve the side not served last (last_served register; after reset exit wins).
REQ-007 GRANT lasts one cycle; matching grant output = 1 only in this cycle; F, capacity, L update on the edge leaving GRANT.
REQ-008 Entry grant: allocate lowest-index free spot; set its F bit; L = that index; capacity -1.
REQ-009 Exit grant: clear F[exit_spot] sampled in IDLE; capacity +1; L unchanged.
REQ-010 OPEN: door_open=1 for exactly DOOR_CYCLES cycles, then CLOSE.
REQ-011 CLOSE: one cycle, door_open=0, requests ignored, then IDLE.
REQ-012 Latency: request sampled at IDLE edge k -> grant in cycle k+1 -> door_open cycles k+2..k+1+DOOR_CYCLES -> CLOSE -> IDLE; back-to-back passages spaced DOOR_CYCLES+3 cycles.
REQ-013 Requests arriving while busy=1 SHALL be held pending, not lost; they are arbitrated on return to IDLE.
REQ-014 full and capacity SHALL be combinational from F; capacity SHALL equal 4 minus popcount(F) at all times.
REQ-015 Entry request while full=1 SHALL never be granted and SHALL not raise exit_err.

Reset
REQ-016 RST=1 asynchronously SHALL force: state IDLE, F=0, capacity=4, full=0, L=0, door_open=0, both grants=0, exit_err=0, busy=0, last_served=entry, spot_time=0.
REQ-017 RST asserted mid-OPEN SHALL drop door_open immediately; pending passage is discarded.

Configuration
REQ-018 Macro GATE_TIMER_EN defined: each spot_time counter increments every cycle its F bit is 1, saturates at 16'hFFFF, clears to 0 on the edge its spot is allocated; value holds after exit until re-allocation.
REQ-019 GATE_TIMER_EN undefined: spot_time SHALL be constant 0 and no counter logic SHALL be instantiated; port list unchanged.

Structure
REQ-020 Package gate_pkg SHALL hold the FSM state enum, NUM_SPOTS=4, spot index type, and dwell counter width 16.
REQ-021 Lowest-free-spot selection SHALL be a sub-module spot_finder (in: F[3:0]; out: index[1:0], none_free).

Verification
REQ-022 Reset then enter_req=1 -> enter_grant in cycle 2, L=0, F=0001, capacity=3, door_open high 4 cycles, busy low after CLOSE.
REQ-023 Four entries -> F=1111, full=1, capacity=0; fifth enter_req held -> no grant until an exit completes, then L=freed index.
REQ-024 F=0101, enter_req and exit_req(spot 2) same cycle -> exit granted first (F=0001), entry granted next passage with L=1.
REQ-025 F=0001, exit_req with exit_spot=3 -> exit_err one-cycle pulse, F unchanged, no door_open.
REQ-026 RST asserted during OPEN cycle 2 -> door_open=0 and F=0 same cycle; with GATE_TIMER_EN, spot 0 occupied 20 cycles -> spot_time[15:0]=20.
